// File: rtl/shell_scheduler.sv
// Shell launch scheduler: edge-detects per-tank fire requests, applies cooldown
// and live-shell caps, arbitrates round-robin onto a shared pool of shell slots.
module shell_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int MAX_PER_TANK = 2,
    parameter int COOLDOWN     = 30,
    parameter int LIFETIME     = 120,
    localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic [1:0]           fire_req,
    input  logic [9:0]           tank0_x,
    input  logic [9:0]           tank0_y,
    input  logic [9:0]           tank1_x,
    input  logic [9:0]           tank1_y,
    input  logic [NUM_SLOTS-1:0] shell_done,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic                 spawn_owner,
    output logic [9:0]           spawn_x,
    output logic [9:0]           spawn_y,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [1:0]           fire_ready
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam int LT_W  = $clog2(LIFETIME + 1);

    typedef enum logic [1:0] {
        READY = 2'd0,
        PEND  = 2'd1,
        COOL  = 2'd2
    } tank_state_e;

    tank_state_e          state_q [2];
    tank_state_e          state_d [2];
    logic [CD_W-1:0]      cool_q  [2];
    logic [CD_W-1:0]      cool_d  [2];
    logic [1:0]           fire_prev_q;
    logic                 rr_q, rr_d;

    logic [NUM_SLOTS-1:0] slot_busy_q, slot_busy_d;
    logic [NUM_SLOTS-1:0] slot_owner_q, slot_owner_d;
    logic [LT_W-1:0]      life_q [NUM_SLOTS];
    logic [LT_W-1:0]      life_d [NUM_SLOTS];

    logic                 spawn_valid_q, spawn_valid_d;
    logic [SLOT_W-1:0]    spawn_slot_q, spawn_slot_d;
    logic                 spawn_owner_q, spawn_owner_d;
    logic [9:0]           spawn_x_q, spawn_x_d;
    logic [9:0]           spawn_y_q, spawn_y_d;
    logic [1:0]           fire_ready_q, fire_ready_d;

    logic [1:0]           evt;
    logic [1:0]           elig;
    logic                 grant;
    logic                 gnt_tank;
    logic                 any_free;
    logic [SLOT_W-1:0]    free_idx;
    logic [CNT_W-1:0]     live_cur [2];

    function automatic logic [CNT_W-1:0] live_count(input logic [NUM_SLOTS-1:0] busy,
                                                    input logic [NUM_SLOTS-1:0] owner,
                                                    input logic             tank);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (busy[i] && (owner[i] == tank)) n = n + CNT_W'(1);
        end
        return n;
    endfunction

    // Lowest-index idle slot, from registered occupancy only.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!any_free && !slot_busy_q[i]) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        evt = fire_req & ~fire_prev_q;
        for (int unsigned t = 0; t < 2; t++) begin
            live_cur[t] = live_count(slot_busy_q, slot_owner_q, 1'(t));
            elig[t]     = (state_q[t] == PEND) && any_free &&
                          (live_cur[t] < CNT_W'(MAX_PER_TANK));
        end
        grant    = |elig;
        gnt_tank = (&elig) ? rr_q : elig[1];
        rr_d     = grant ? ~gnt_tank : rr_q;
    end

    always_comb begin
        for (int unsigned t = 0; t < 2; t++) begin
            state_d[t] = state_q[t];
            cool_d[t]  = cool_q[t];
            case (state_q[t])
                READY: if (evt[t]) state_d[t] = PEND;
                PEND: begin
                    if (grant && (gnt_tank == 1'(t))) begin
                        state_d[t] = COOL;
                        cool_d[t]  = CD_W'(COOLDOWN);
                    end
                end
                COOL: begin
                    // Counter reaches 0 on the same edge the tank returns to READY.
                    if (cool_q[t] <= CD_W'(1)) begin
                        state_d[t] = READY;
                        cool_d[t]  = '0;
                    end else begin
                        cool_d[t] = cool_q[t] - CD_W'(1);
                    end
                end
                default: begin
                    state_d[t] = READY;
                    cool_d[t]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        slot_busy_d  = slot_busy_q;
        slot_owner_d = slot_owner_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            life_d[i] = life_q[i];
            if (slot_busy_q[i]) begin
                if (shell_done[i] || (life_q[i] == LT_W'(1))) begin
                    slot_busy_d[i] = 1'b0;
                    life_d[i]      = '0;
                end else begin
                    life_d[i] = life_q[i] - LT_W'(1);
                end
            end
            if (grant && (free_idx == SLOT_W'(i))) begin
                slot_busy_d[i]  = 1'b1;
                slot_owner_d[i] = gnt_tank;
                life_d[i]       = LT_W'(LIFETIME);
            end
        end
    end

    always_comb begin
        spawn_valid_d = grant;
        spawn_slot_d  = spawn_slot_q;
        spawn_owner_d = spawn_owner_q;
        spawn_x_d     = spawn_x_q;
        spawn_y_d     = spawn_y_q;
        if (grant) begin
            spawn_slot_d  = free_idx;
            spawn_owner_d = gnt_tank;
            spawn_x_d     = gnt_tank ? tank1_x : tank0_x;
            spawn_y_d     = gnt_tank ? tank1_y : tank0_y;
        end
        // fire_ready reflects the post-edge state so it never lags a transition.
        for (int unsigned t = 0; t < 2; t++) begin
            fire_ready_d[t] = (state_d[t] == READY) &&
                              (live_count(slot_busy_d, slot_owner_d, 1'(t)) < CNT_W'(MAX_PER_TANK));
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned t = 0; t < 2; t++) begin
                state_q[t] <= READY;
                cool_q[t]  <= '0;
            end
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                life_q[i] <= '0;
            end
            fire_prev_q   <= '0;
            rr_q          <= 1'b0;
            slot_busy_q   <= '0;
            slot_owner_q  <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_owner_q <= 1'b0;
            spawn_x_q     <= '0;
            spawn_y_q     <= '0;
            fire_ready_q  <= '0;
        end else begin
            for (int unsigned t = 0; t < 2; t++) begin
                state_q[t] <= state_d[t];
                cool_q[t]  <= cool_d[t];
            end
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                life_q[i] <= life_d[i];
            end
            fire_prev_q   <= fire_req;
            rr_q          <= rr_d;
            slot_busy_q   <= slot_busy_d;
            slot_owner_q  <= slot_owner_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_owner_q <= spawn_owner_d;
            spawn_x_q     <= spawn_x_d;
            spawn_y_q     <= spawn_y_d;
            fire_ready_q  <= fire_ready_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_owner = spawn_owner_q;
    assign spawn_x     = spawn_x_q;
    assign spawn_y     = spawn_y_q;
    assign slot_busy   = slot_busy_q;
    assign slot_owner  = slot_owner_q;
    assign fire_ready  = fire_ready_q;

endmodule

// File: tb/tb_shell_scheduler.sv
// Directed bench for shell_scheduler: table-driven first launch, then hand
// sequences for arbitration, caps, full pool, lifetime and mid-run reset.
module tb_shell_scheduler;

    logic       frame_clk;
    logic       Reset_n;
    logic [1:0] fire_req;
    logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y;
    logic [3:0] shell_done;
    logic       spawn_valid;
    logic [1:0] spawn_slot;
    logic       spawn_owner;
    logic [9:0] spawn_x, spawn_y;
    logic [3:0] slot_busy;
    logic [3:0] slot_owner;
    logic [1:0] fire_ready;

    int n_chk;
    int n_err;
    int edge_n;
    int spawn_cnt;
    int base;

    shell_scheduler #(
        .NUM_SLOTS   (4),
        .MAX_PER_TANK(2),
        .COOLDOWN    (30),
        .LIFETIME    (120)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .fire_req   (fire_req),
        .tank0_x    (tank0_x),
        .tank0_y    (tank0_y),
        .tank1_x    (tank1_x),
        .tank1_y    (tank1_y),
        .shell_done (shell_done),
        .spawn_valid(spawn_valid),
        .spawn_slot (spawn_slot),
        .spawn_owner(spawn_owner),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .slot_busy  (slot_busy),
        .slot_owner (slot_owner),
        .fire_ready (fire_ready)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [1:0] fire;
        logic [3:0] done;
        logic       exp_valid;
        logic [1:0] exp_slot;
        logic       exp_owner;
        logic [3:0] exp_busy;
        logic [1:0] exp_ready;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #2;
        edge_n++;
        if (spawn_valid === 1'b1) spawn_cnt++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset();
        fire_req   = 2'b00;
        shell_done = 4'b0000;
        Reset_n    = 1'b0;
        @(posedge frame_clk);
        #2;
        Reset_n   = 1'b1;
        edge_n    = 0;
        spawn_cnt = 0;
    endtask

    task automatic chk_spawn(input string name, input logic [1:0] slot, input logic owner);
        chk({name, "_valid"}, 32'(spawn_valid), 32'd1);
        chk({name, "_slot"},  32'(spawn_slot),  32'(slot));
        chk({name, "_owner"}, 32'(spawn_owner), 32'(owner));
    endtask

    initial begin
        n_chk = 0; n_err = 0; edge_n = 0; spawn_cnt = 0;
        tank0_x = 10'd100; tank0_y = 10'd200;
        tank1_x = 10'd300; tank1_y = 10'd400;
        fire_req = 2'b00; shell_done = 4'b0000;
        Reset_n = 1'b0;

        // Reset state, sampled while reset is still asserted.
        #1;
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_busy",  32'(slot_busy),   32'd0);
        chk("rst_owner", 32'(slot_owner),  32'd0);
        chk("rst_ready", 32'(fire_ready),  32'd0);
        chk("rst_x",     32'(spawn_x),     32'd0);

        // First launch: tank0 rises at edge 5, spawns at edge 6.
        tbl[0] = '{2'b00, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'b11};
        tbl[1] = '{2'b00, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'b11};
        tbl[2] = '{2'b00, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'b11};
        tbl[3] = '{2'b00, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'b11};
        tbl[4] = '{2'b01, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'b10};
        tbl[5] = '{2'b01, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 2'b10};
        tbl[6] = '{2'b01, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001, 2'b10};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            fire_req   = tbl[i].fire;
            shell_done = tbl[i].done;
            tick();
            chk("tbl_valid", 32'(spawn_valid), 32'(tbl[i].exp_valid));
            chk("tbl_busy",  32'(slot_busy),   32'(tbl[i].exp_busy));
            chk("tbl_ready", 32'(fire_ready),  32'(tbl[i].exp_ready));
            if (tbl[i].exp_valid) begin
                chk("tbl_slot",  32'(spawn_slot),  32'(tbl[i].exp_slot));
                chk("tbl_owner", 32'(spawn_owner), 32'(tbl[i].exp_owner));
                chk("tbl_x", 32'(spawn_x), tbl[i].exp_owner ? 32'd300 : 32'd100);
                chk("tbl_y", 32'(spawn_y), tbl[i].exp_owner ? 32'd400 : 32'd200);
            end
        end
        // Cooldown: granted at edge 6, READY again at edge 36.
        run_to(35);
        chk("cool_hold", 32'(fire_ready), 32'b10);
        tick();
        chk("cool_done", 32'(fire_ready), 32'b11);
        // Lifetime: busy after edges 6..125, free at edge 126.
        run_to(125);
        chk("life_last", 32'(slot_busy), 32'b0001);
        tick();
        chk("life_expire", 32'(slot_busy), 32'b0000);
        // fire_req held high from edge 5 through edge 204.
        run_to(204);
        chk("held_once", 32'(spawn_cnt), 32'd1);
        fire_req = 2'b00; tick();
        fire_req = 2'b01; tick();
        tick();
        chk_spawn("repress", 2'd0, 1'b0);
        fire_req = 2'b00; tick();
        fire_req = 2'b01; tick();
        fire_req = 2'b00;
        base = spawn_cnt;
        run_to(260);
        chk("cool_drop", 32'(spawn_cnt - base), 32'd0);
        chk("cool_drop_ready", 32'(fire_ready), 32'b11);

        // Tie from reset: tank0 first, tank1 next edge.
        do_reset();
        fire_req = 2'b11; tick();
        chk("tie_pend_ready", 32'(fire_ready), 32'b00);
        chk("tie_pend_valid", 32'(spawn_valid), 32'd0);
        tick();
        chk_spawn("tie_first", 2'd0, 1'b0);
        tick();
        chk_spawn("tie_second", 2'd1, 1'b1);
        chk("tie_busy",  32'(slot_busy),  32'b0011);
        chk("tie_owner", 32'(slot_owner), 32'b0010);
        fire_req = 2'b00; shell_done = 4'b0011; tick();
        chk("done_both", 32'(slot_busy), 32'b0000);
        shell_done = 4'b0000;
        run_to(34);
        fire_req = 2'b01; tick();
        fire_req = 2'b00; tick();
        chk_spawn("solo0", 2'd0, 1'b0);
        // Tank0 was granted last, so the next tie goes to tank1.
        run_to(67);
        fire_req = 2'b11; tick();
        fire_req = 2'b00; tick();
        chk_spawn("tie2_first", 2'd1, 1'b1);
        tick();
        chk_spawn("tie2_second", 2'd2, 1'b0);

        // Per-tank cap: tank0 with two live shells is held in PEND.
        do_reset();
        fire_req = 2'b01; tick();
        fire_req = 2'b00; tick();
        chk_spawn("cap_a", 2'd0, 1'b0);
        run_to(32);
        fire_req = 2'b01; tick();
        fire_req = 2'b00; tick();
        chk_spawn("cap_b", 2'd1, 1'b0);
        run_to(64);
        chk("cap_ready", 32'(fire_ready), 32'b10);
        fire_req = 2'b01; tick();
        fire_req = 2'b00;
        base = spawn_cnt;
        run_to(70);
        chk("cap_hold", 32'(spawn_cnt - base), 32'd0);
        chk("cap_busy", 32'(slot_busy), 32'b0011);
        shell_done = 4'b0001; tick();
        chk("done_free_valid", 32'(spawn_valid), 32'd0);
        chk("done_free_busy",  32'(slot_busy),   32'b0010);
        shell_done = 4'b0000; tick();
        chk_spawn("cap_grant", 2'd0, 1'b0);
        chk("cap_grant_busy", 32'(slot_busy), 32'b0011);

        // Full pool: tank1 pending until its slot2 expires.
        do_reset();
        fire_req = 2'b11; tick();
        fire_req = 2'b00; tick();
        tick();
        run_to(33);
        fire_req = 2'b10; tick();
        fire_req = 2'b00; tick();
        chk_spawn("full_s2", 2'd2, 1'b1);
        fire_req = 2'b01; tick();
        fire_req = 2'b00; tick();
        chk_spawn("full_s3", 2'd3, 1'b0);
        chk("full_busy", 32'(slot_busy), 32'b1111);
        shell_done = 4'b0010; tick();
        chk("full_done1", 32'(slot_busy), 32'b1101);
        shell_done = 4'b0000;
        run_to(65);
        fire_req = 2'b10; tick();
        fire_req = 2'b00; tick();
        chk_spawn("full_s1", 2'd1, 1'b1);
        run_to(122);
        chk("full_s0_expire", 32'(slot_busy), 32'b1110);
        fire_req = 2'b01; tick();
        fire_req = 2'b00; tick();
        chk_spawn("full_s0", 2'd0, 1'b0);
        run_to(129);
        fire_req = 2'b10; tick();
        fire_req = 2'b00;
        base = spawn_cnt;
        run_to(154);
        chk("full_hold", 32'(spawn_cnt - base), 32'd0);
        chk("full_hold_busy",  32'(slot_busy),  32'b1111);
        chk("full_hold_owner", 32'(slot_owner), 32'b0110);
        tick();
        chk("expire_s2_busy",  32'(slot_busy),   32'b1011);
        chk("expire_s2_valid", 32'(spawn_valid), 32'd0);
        tick();
        chk_spawn("expire_grant", 2'd2, 1'b1);

        // Mid-operation reset with tank1 pending and slot0 busy.
        do_reset();
        fire_req = 2'b11; tick();
        tick();
        chk_spawn("mid_pre", 2'd0, 1'b0);
        Reset_n  = 1'b0;
        fire_req = 2'b00;
        #1;
        chk("mid_rst_busy",  32'(slot_busy),   32'd0);
        chk("mid_rst_ready", 32'(fire_ready),  32'd0);
        chk("mid_rst_valid", 32'(spawn_valid), 32'd0);
        @(posedge frame_clk);
        #2;
        chk("mid_rst_hold", 32'(spawn_valid), 32'd0);
        Reset_n = 1'b1;
        edge_n  = 0;
        tick();
        chk("mid_rel_ready", 32'(fire_ready),  32'b11);
        chk("mid_rel_busy",  32'(slot_busy),   32'd0);
        chk("mid_rel_valid", 32'(spawn_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
